retirement_rat: RTL and testbench

Retirement register alias table downstream of the reorder buffer's commit stage. It holds the committed architectural-to-physical register mapping. On each commit it overwrites the mapping and queues the previously mapped physical register for return to the rename free list. On a branch flush it streams the committed mapping, one architectural register per cycle, back to the front-end RAT for recovery.

---
 rtl/retirement_rat.sv | 135 +++++++++++++
 tb/tb_retirement_rat.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/retirement_rat.sv
// Retirement RAT: committed arch->phys map, freed-tag queue toward the rename
// free list, and a one-entry-per-cycle recovery walk after a branch flush.
module retirement_rat #(
  parameter int ARCH_REGS    = 32,
  parameter int PHYS_REGS    = 64,
  parameter int COMMIT_WIDTH = 2,
  parameter int FREE_Q_DEPTH = 16,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS)
) (
  input  logic                             clk_in,
  input  logic                             rst_N_in,
  input  logic [COMMIT_WIDTH-1:0]          commit_valid_in,
  input  logic [COMMIT_WIDTH-1:0][AW-1:0]  commit_arch_in,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  commit_phys_in,
  output logic                             commit_ready_out,
  input  logic                             flush_in,
  output logic                             free_valid_out,
  output logic [PW-1:0]                    free_preg_out,
  input  logic                             free_ready_in,
  output logic                             recover_valid_out,
  output logic [AW-1:0]                    recover_arch_out,
  output logic [PW-1:0]                    recover_phys_out,
  output logic                             recover_busy_out
);

  localparam int QW = $clog2(FREE_Q_DEPTH);
  localparam int CW = $clog2(FREE_Q_DEPTH + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(ARCH_REGS - 1);
  localparam logic [CW-1:0] READY_MAX = CW'(FREE_Q_DEPTH - COMMIT_WIDTH);

  typedef enum logic [0:0] {IDLE, RECOVER} state_e;

  state_e          state_p1, state_nxt_p0;
  logic [AW-1:0]   idx_p1;
  logic [PW-1:0]   map_p1 [ARCH_REGS];
  logic [PW-1:0]   fq_p1  [FREE_Q_DEPTH];
  logic [QW-1:0]   head_p1, tail_p1;
  logic [CW-1:0]   cnt_p1;

  logic [COMMIT_WIDTH-1:0] push_vld_p0;
  logic [PW-1:0]           old_p0  [COMMIT_WIDTH];
  logic [QW-1:0]           slot_p0 [COMMIT_WIDTH];
  logic [CW-1:0]           push_cnt_p0;
  logic                    pop_p0;

  // ---- stage p0: commit decode against the current map and queue tail ----
  assign push_vld_p0 = commit_ready_out ? commit_valid_in : '0;
  assign pop_p0      = (cnt_p1 != '0) && free_ready_in;

  always_comb begin
    push_cnt_p0 = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      // a younger lane hitting the same arch reg displaces the older lane's tag
      old_p0[i] = map_p1[commit_arch_in[i]];
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (j < i && push_vld_p0[j] && commit_arch_in[j] == commit_arch_in[i])
          old_p0[i] = commit_phys_in[j];
      end
      slot_p0[i] = tail_p1 + QW'(push_cnt_p0);
      if (push_vld_p0[i])
        push_cnt_p0 = push_cnt_p0 + CW'(1);
    end
  end

  // ---- stage p1: architectural map, queue and walk state ----
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int k = 0; k < ARCH_REGS; k++)
        map_p1[k] <= PW'(k);
    end else begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (push_vld_p0[i])
          map_p1[commit_arch_in[i]] <= commit_phys_in[i];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (push_vld_p0[i])
        fq_p1[slot_p0[i]] <= old_p0[i];
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      head_p1 <= '0;
      tail_p1 <= '0;
      cnt_p1  <= '0;
    end else begin
      if (pop_p0)
        head_p1 <= head_p1 + QW'(1);
      tail_p1 <= tail_p1 + QW'(push_cnt_p0);
      cnt_p1  <= cnt_p1 + push_cnt_p0 - CW'(pop_p0);
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in)
      state_p1 <= IDLE;
    else
      state_p1 <= state_nxt_p0;
  end

  always_comb begin
    state_nxt_p0 = state_p1;
    case (state_p1)
      IDLE:    if (flush_in) state_nxt_p0 = RECOVER;
      RECOVER: if (!flush_in && idx_p1 == LAST_IDX) state_nxt_p0 = IDLE;
      default: state_nxt_p0 = IDLE;
    endcase
  end

  // walk index sits at 0 whenever idle, so a flush always starts from arch 0
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in)
      idx_p1 <= '0;
    else if (state_p1 == RECOVER && !flush_in && idx_p1 != LAST_IDX)
      idx_p1 <= idx_p1 + AW'(1);
    else
      idx_p1 <= '0;
  end

  always_comb begin
    recover_valid_out = (state_p1 == RECOVER);
    recover_busy_out  = recover_valid_out;
    recover_arch_out  = recover_valid_out ? idx_p1 : '0;
    recover_phys_out  = recover_valid_out ? map_p1[idx_p1] : '0;
    commit_ready_out  = (state_p1 == IDLE) && (cnt_p1 <= READY_MAX);
    free_valid_out    = (cnt_p1 != '0);
    free_preg_out     = free_valid_out ? fq_p1[head_p1] : '0;
  end

endmodule

// File: tb/tb_retirement_rat.sv
// Bench for retirement_rat: directed vector table, hand-written corner
// sequences and a randomized run against a queue/array reference model.
module tb_retirement_rat;

  localparam int AR  = 32;
  localparam int PR  = 64;
  localparam int CWD = 2;
  localparam int QD  = 16;
  localparam int AW  = 5;
  localparam int PW  = 6;

  logic                 clk_in = 1'b0;
  logic                 rst_N_in;
  logic [1:0]           commit_valid_in;
  logic [1:0][AW-1:0]   commit_arch_in;
  logic [1:0][PW-1:0]   commit_phys_in;
  logic                 commit_ready_out;
  logic                 flush_in;
  logic                 free_valid_out;
  logic [PW-1:0]        free_preg_out;
  logic                 free_ready_in;
  logic                 recover_valid_out;
  logic [AW-1:0]        recover_arch_out;
  logic [PW-1:0]        recover_phys_out;
  logic                 recover_busy_out;

  retirement_rat #(.ARCH_REGS(AR), .PHYS_REGS(PR), .COMMIT_WIDTH(CWD), .FREE_Q_DEPTH(QD)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .commit_valid_in(commit_valid_in), .commit_arch_in(commit_arch_in),
    .commit_phys_in(commit_phys_in), .commit_ready_out(commit_ready_out),
    .flush_in(flush_in), .free_valid_out(free_valid_out), .free_preg_out(free_preg_out),
    .free_ready_in(free_ready_in), .recover_valid_out(recover_valid_out),
    .recover_arch_out(recover_arch_out), .recover_phys_out(recover_phys_out),
    .recover_busy_out(recover_busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model: committed map as a plain array, freed tags as a queue,
  // walk position as an integer (-1 when no walk is in progress)
  int m_map [AR];
  int m_q [$];
  int m_walk;

  function automatic void model_reset();
    for (int k = 0; k < AR; k++) m_map[k] = k;
    m_q.delete();
    m_walk = -1;
  endfunction

  function automatic bit m_ready();
    return (m_walk < 0) && (m_q.size() <= QD - CWD);
  endfunction

  function automatic void model_step();
    bit rdy;
    rdy = m_ready();
    if (free_ready_in && m_q.size() > 0) void'(m_q.pop_front());
    if (rdy) begin
      for (int i = 0; i < CWD; i++) begin
        if (commit_valid_in[i]) begin
          m_q.push_back(m_map[commit_arch_in[i]]);
          m_map[commit_arch_in[i]] = commit_phys_in[i];
        end
      end
    end
    if (flush_in)             m_walk = 0;
    else if (m_walk == AR-1)  m_walk = -1;
    else if (m_walk >= 0)     m_walk = m_walk + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("free_valid",    32'(free_valid_out),    32'(m_q.size() != 0));
    chk("free_preg",     32'(free_preg_out),     (m_q.size() != 0) ? m_q[0] : 0);
    chk("commit_ready",  32'(commit_ready_out),  32'(m_ready()));
    chk("recover_valid", 32'(recover_valid_out), 32'(m_walk >= 0));
    chk("recover_busy",  32'(recover_busy_out),  32'(m_walk >= 0));
    chk("recover_arch",  32'(recover_arch_out),  (m_walk >= 0) ? m_walk : 0);
    chk("recover_phys",  32'(recover_phys_out),  (m_walk >= 0) ? m_map[m_walk] : 0);
  endtask

  task automatic drive(input logic [1:0] cv, input int a0, input int p0,
                       input int a1, input int p1, input logic fl, input logic fr);
    commit_valid_in   = cv;
    commit_arch_in[0] = AW'(a0);
    commit_phys_in[0] = PW'(p0);
    commit_arch_in[1] = AW'(a1);
    commit_phys_in[1] = PW'(p1);
    flush_in          = fl;
    free_ready_in     = fr;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  // commits must never be presented while the block is not ready
  always @(negedge clk_in) begin
    if (rst_N_in && commit_valid_in != 2'b00) begin
      assert (commit_ready_out)
      else begin
        n_fails++;
        $display("FAIL protocol: commit_valid_in=%0d while commit_ready_out=%0d",
                 commit_valid_in, commit_ready_out);
      end
    end
  end

  typedef struct {
    logic [1:0] cv;
    int a0, p0, a1, p1;
    logic fl, fr;
    logic e_fv; int e_fp; logic e_rdy; logic e_rv; int e_ra; int e_rp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int exp_p;
    tbl[0] = '{2'b00, 0, 0,  0, 0,  1'b0, 1'b0, 1'b0, 0,  1'b1, 1'b0, 0, 0};
    tbl[1] = '{2'b01, 3, 40, 0, 0,  1'b0, 1'b0, 1'b1, 3,  1'b1, 1'b0, 0, 0};
    tbl[2] = '{2'b11, 5, 41, 5, 42, 1'b0, 1'b1, 1'b1, 5,  1'b1, 1'b0, 0, 0};
    tbl[3] = '{2'b00, 0, 0,  0, 0,  1'b0, 1'b1, 1'b1, 41, 1'b1, 1'b0, 0, 0};
    tbl[4] = '{2'b00, 0, 0,  0, 0,  1'b0, 1'b1, 1'b0, 0,  1'b1, 1'b0, 0, 0};
    tbl[5] = '{2'b00, 0, 0,  0, 0,  1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b1, 0, 0};

    rst_N_in = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_free_valid",    32'(free_valid_out),    0);
    chk("rst_recover_valid", 32'(recover_valid_out), 0);
    #3 rst_N_in = 1'b1;
    repeat (2) begin
      tick();
      check_model();
    end

    // directed vectors: single commit, same-arch pair, pops, flush
    for (int v = 0; v < 6; v++) begin
      drive(tbl[v].cv, tbl[v].a0, tbl[v].p0, tbl[v].a1, tbl[v].p1, tbl[v].fl, tbl[v].fr);
      tick();
      chk($sformatf("v%0d_free_valid", v),    32'(free_valid_out),    32'(tbl[v].e_fv));
      chk($sformatf("v%0d_free_preg", v),     32'(free_preg_out),     tbl[v].e_fp);
      chk($sformatf("v%0d_commit_ready", v),  32'(commit_ready_out),  32'(tbl[v].e_rdy));
      chk($sformatf("v%0d_recover_valid", v), 32'(recover_valid_out), 32'(tbl[v].e_rv));
      chk($sformatf("v%0d_recover_busy", v),  32'(recover_busy_out),  32'(tbl[v].e_rv));
      chk($sformatf("v%0d_recover_arch", v),  32'(recover_arch_out),  tbl[v].e_ra);
      chk($sformatf("v%0d_recover_phys", v),  32'(recover_phys_out),  tbl[v].e_rp);
    end

    // rest of the walk: arch 3 -> 40, arch 5 -> 42, everything else identity
    drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int b = 1; b < AR; b++) begin
      tick();
      exp_p = (b == 3) ? 40 : (b == 5) ? 42 : b;
      chk($sformatf("walk%0d_arch", b), 32'(recover_arch_out), b);
      chk($sformatf("walk%0d_phys", b), 32'(recover_phys_out), exp_p);
    end
    tick();
    chk("walk_done_valid", 32'(recover_valid_out), 0);
    chk("walk_done_ready", 32'(commit_ready_out),  1);

    // fill the queue with no consumer: one single commit, then pairs
    drive(2'b01, 1, 50, 0, 0, 1'b0, 1'b0);
    tick();
    check_model();
    for (int n = 0; n < 20 && m_ready(); n++) begin
      drive(2'b11, $urandom_range(0, AR-1), $urandom_range(0, PR-1),
            $urandom_range(0, AR-1), $urandom_range(0, PR-1), 1'b0, 1'b0);
      tick();
      check_model();
    end
    drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("full_ready_low", 32'(commit_ready_out), 0);
    chk("full_free_valid", 32'(free_valid_out),  1);
    check_model();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b1);
    tick();
    chk("ready_after_pop", 32'(commit_ready_out), 1);
    check_model();
    for (int n = 0; n < 20 && m_q.size() > 0; n++) begin
      tick();
      check_model();
    end

    // flush at walk index 10 restarts at 0 and completes a full 32-beat walk
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    tick();
    check_model();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      tick();
      check_model();
    end
    chk("pre_restart_arch", 32'(recover_arch_out), 10);
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    tick();
    chk("restart_arch", 32'(recover_arch_out), 0);
    check_model();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int n = 0; n < AR; n++) begin
      tick();
      check_model();
    end
    chk("restart_end_valid", 32'(recover_valid_out), 0);

    // asynchronous reset mid-walk with a non-empty queue
    drive(2'b11, 7, 33, 9, 34, 1'b0, 1'b0);
    tick();
    check_model();
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    repeat (4) tick();
    check_model();
    #2 rst_N_in = 1'b0;
    #1;
    chk("arst_free_valid",    32'(free_valid_out),    0);
    chk("arst_free_preg",     32'(free_preg_out),     0);
    chk("arst_recover_valid", 32'(recover_valid_out), 0);
    chk("arst_recover_busy",  32'(recover_busy_out),  0);
    chk("arst_recover_arch",  32'(recover_arch_out),  0);
    chk("arst_recover_phys",  32'(recover_phys_out),  0);
    #2 rst_N_in = 1'b1;
    model_reset();
    tick();
    check_model();
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    tick();
    check_model();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int n = 1; n < AR; n++) begin
      tick();
      chk($sformatf("post_rst_map%0d", n), 32'(recover_phys_out), n);
    end

    // randomized traffic; consumer pressure varies per block so the queue fills
    for (int n = 0; n < 1500; n++) begin
      logic [1:0] cv;
      logic fr;
      cv = m_ready() ? 2'($urandom_range(0, 3)) : 2'b00;
      fr = ((n / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(cv, $urandom_range(0, 7), $urandom_range(0, PR-1),
            $urandom_range(0, 7), $urandom_range(0, PR-1),
            ($urandom_range(0, 39) == 0), fr);
      tick();
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
